// File: rtl/optical_rx_prbs_checker.sv
// optical_rx_prbs_checker
// Receive-side PRBS-31 checker for the optical link. It consumes 32-bit GTP RX
// words, finds the FCFCFCFC/K start marker, seeds a PRBS-31 (x^31+x^28+1)
// predictor from the first complete frame and then checks the 48-bit payload
// and the BC50 comma of every following 64-bit frame.
// Frame layout: hi word = payload[47:16]; lo word = {payload[15:0], 16'hBC50},
// with rx_charisk[1] set on the lo word. Payload bit 47 is the earliest bit.
// Optional feature: define OPTICAL_RX_BITERR_EN to add the bit_err_cnt port,
// a saturating count of mismatched payload bits over all checked frames.
module optical_rx_prbs_checker #(
   parameter int ERR_CNT_W   = 16,
   parameter int FRAME_CNT_W = 32,
   parameter int LOCK_LOSS   = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [31:0]            rx_data,
   input  logic [3:0]             rx_charisk,
   input  logic                   rx_valid,
   input  logic                   clr_cnt,
   output logic                   locked,
   output logic                   start_seen,
   output logic                   frame_err,
   output logic [ERR_CNT_W-1:0]   err_cnt,
   output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef OPTICAL_RX_BITERR_EN
   ,
   output logic [31:0]            bit_err_cnt
`endif
);

   localparam logic [31:0] START_MARKER = 32'hFCFCFCFC;
   localparam logic [3:0]  START_K      = 4'b1111;
   localparam logic [15:0] COMMA_WORD   = 16'hBC50;
   localparam logic [3:0]  LOCK_LOSS_C  = 4'(LOCK_LOSS);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SEED   = 2'd1,
      ST_CHECK  = 2'd2
   } state_t;

   // Advance the PRBS-31 predictor by one 48-bit payload.
   // st[30] holds s[n-31] (oldest), st[0] holds s[n-1] (newest).
   // Result is {48-bit prediction (bit 47 earliest), new 31-bit state}.
   function automatic logic [78:0] prbs_advance48(input logic [30:0] st);
      logic [30:0] s;
      logic [47:0] p;
      logic        nb;
      s = st;
      p = 48'd0;
      for (int i = 47; i >= 0; i--) begin
         nb   = s[30] ^ s[27];
         p[i] = nb;
         s    = {s[29:0], nb};
      end
      return {p, s};
   endfunction

`ifdef OPTICAL_RX_BITERR_EN
   // Number of set bits in a 48-bit mismatch vector.
   function automatic logic [5:0] popcount48(input logic [47:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < 48; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction
`endif

   state_t                 state_q, state_d;
   logic                   phase_q, phase_d;
   logic [31:0]            hi_q, hi_d;
   logic [30:0]            pred_q, pred_d;
   logic [3:0]             run_q, run_d;
   logic                   locked_q, locked_d;
   logic                   start_seen_q, start_seen_d;
   logic                   frame_err_q, frame_err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic [47:0] pred_word_s;
   logic [30:0] pred_next_s;
   logic [47:0] payload_s;
   logic        marker_s;
   logic        comma_ok_s;
   logic        payload_ok_s;
   logic [3:0]  run_inc_s;
   logic        frame_inc_s;
   logic        err_inc_s;

   assign {pred_word_s, pred_next_s} = prbs_advance48(pred_q);
   assign payload_s    = {hi_q, rx_data[31:16]};
   assign marker_s     = rx_valid && (rx_data == START_MARKER) && (rx_charisk == START_K);
   assign comma_ok_s   = (rx_data[15:0] == COMMA_WORD) && rx_charisk[1];
   assign payload_ok_s = (payload_s == pred_word_s);
   assign run_inc_s    = run_q + 4'd1;

   // Frame alignment, seeding and lock state machine next-state logic.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      pred_d       = pred_q;
      run_d        = run_q;
      start_seen_d = 1'b0;
      frame_err_d  = 1'b0;
      frame_inc_s  = 1'b0;
      err_inc_s    = 1'b0;
      if (!rx_valid) begin
         // Link not usable: drop back to hunting, counters untouched.
         state_d = ST_SEARCH;
         phase_d = 1'b0;
         run_d   = 4'd0;
      end else if (marker_s) begin
         // A marker always restarts alignment; any partial frame is dropped silently.
         state_d      = ST_SEED;
         phase_d      = 1'b0;
         run_d        = 4'd0;
         start_seen_d = 1'b1;
      end else begin
         case (state_q)
            ST_SEARCH: begin
               phase_d = 1'b0;
            end
            ST_SEED: begin
               if (!phase_q) begin
                  // Bonding/K words between marker and seed frame are skipped.
                  if (rx_charisk == 4'b0000) begin
                     hi_d    = rx_data;
                     phase_d = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                  end
               end else begin
                  // Last 31 payload bits become the predictor history.
                  pred_d  = payload_s[30:0];
                  phase_d = 1'b0;
                  run_d   = 4'd0;
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!phase_q) begin
                  hi_d    = rx_data;
                  phase_d = 1'b1;
               end else begin
                  // Predictor free-runs so a single bit hit is counted once.
                  phase_d     = 1'b0;
                  pred_d      = pred_next_s;
                  frame_inc_s = 1'b1;
                  if (payload_ok_s && comma_ok_s) begin
                     run_d = 4'd0;
                  end else begin
                     err_inc_s   = 1'b1;
                     frame_err_d = 1'b1;
                     if (run_inc_s >= LOCK_LOSS_C) begin
                        state_d = ST_SEARCH;
                        run_d   = 4'd0;
                     end else begin
                        run_d = run_inc_s;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_SEARCH;
               phase_d = 1'b0;
               run_d   = 4'd0;
            end
         endcase
      end
      locked_d = (state_d == ST_CHECK);
   end

   // Saturating frame/error counters; a clear overrides a coincident increment.
   always_comb begin
      err_cnt_d   = err_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (clr_cnt) begin
         err_cnt_d   = {ERR_CNT_W{1'b0}};
         frame_cnt_d = {FRAME_CNT_W{1'b0}};
      end else begin
         if (err_inc_s && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end else begin
            err_cnt_d = err_cnt_q;
         end
         if (frame_inc_s && !(&frame_cnt_q)) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
         end else begin
            frame_cnt_d = frame_cnt_q;
         end
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_SEARCH;
         phase_q      <= 1'b0;
         hi_q         <= 32'd0;
         pred_q       <= 31'd0;
         run_q        <= 4'd0;
         locked_q     <= 1'b0;
         start_seen_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_cnt_q    <= {ERR_CNT_W{1'b0}};
         frame_cnt_q  <= {FRAME_CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         pred_q       <= pred_d;
         run_q        <= run_d;
         locked_q     <= locked_d;
         start_seen_q <= start_seen_d;
         frame_err_q  <= frame_err_d;
         err_cnt_q    <= err_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign locked     = locked_q;
   assign start_seen = start_seen_q;
   assign frame_err  = frame_err_q;
   assign err_cnt    = err_cnt_q;
   assign frame_cnt  = frame_cnt_q;

`ifdef OPTICAL_RX_BITERR_EN
   logic [31:0] bit_err_cnt_q, bit_err_cnt_d;
   logic [32:0] bit_sum_s;

   assign bit_sum_s = {1'b0, bit_err_cnt_q} + {27'd0, popcount48(payload_s ^ pred_word_s)};

   // Saturating sum of payload bit mismatches over checked frames.
   always_comb begin
      bit_err_cnt_d = bit_err_cnt_q;
      if (clr_cnt) begin
         bit_err_cnt_d = 32'd0;
      end else if (frame_inc_s) begin
         if (bit_sum_s[32]) begin
            bit_err_cnt_d = 32'hFFFF_FFFF;
         end else begin
            bit_err_cnt_d = bit_sum_s[31:0];
         end
      end else begin
         bit_err_cnt_d = bit_err_cnt_q;
      end
   end

   // Bit error counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_err_cnt_q <= 32'd0;
      end else begin
         bit_err_cnt_q <= bit_err_cnt_d;
      end
   end

   assign bit_err_cnt = bit_err_cnt_q;
`endif

endmodule

// File: tb/tb_optical_rx_prbs_checker.sv
// Self-checking bench for optical_rx_prbs_checker. An independent PRBS-31
// generator (bit history, s[n]=s[n-31]^s[n-28]) builds the transmitted frames;
// each driven word pushes its expected outputs to a scoreboard that a negedge
// monitor pops and compares once the DUT has registered that word.
module tb_optical_rx_prbs_checker;

   localparam int ERR_W = 4;
   localparam int LL    = 4;
   localparam int S_SEARCH = 0;
   localparam int S_SEED   = 1;
   localparam int S_CHECK  = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] rx_data = 32'd0;
   logic [3:0]  rx_charisk = 4'd0;
   logic        rx_valid = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        locked, start_seen, frame_err;
   logic [ERR_W-1:0] err_cnt;
   logic [31:0] frame_cnt;
`ifdef OPTICAL_RX_BITERR_EN
   logic [31:0] bit_err_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int               due;
      logic             fe;
      logic             ss;
      logic             lk;
      logic [ERR_W-1:0] ec;
      logic [31:0]      fc;
      logic [31:0]      bc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   bit   hist[$];

   int               m_st;
   int               m_run;
   logic             m_lk;
   logic [ERR_W-1:0] m_err;
   logic [31:0]      m_frm;
   logic [31:0]      m_bit;

   optical_rx_prbs_checker #(
      .ERR_CNT_W  (ERR_W),
      .FRAME_CNT_W(32),
      .LOCK_LOSS  (LL)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_charisk (rx_charisk),
      .rx_valid   (rx_valid),
      .clr_cnt    (clr_cnt),
      .locked     (locked),
      .start_seen (start_seen),
      .frame_err  (frame_err),
      .err_cnt    (err_cnt),
      .frame_cnt  (frame_cnt)
`ifdef OPTICAL_RX_BITERR_EN
      ,
      .bit_err_cnt(bit_err_cnt)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard monitor: compare every expectation that is due this cycle.
   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         total++;
         if (frame_err !== mon_e.fe) begin
            bad++;
            $display("FAIL sb_frame_err cyc=%0d got=%b exp=%b", cyc, frame_err, mon_e.fe);
         end
         total++;
         if (start_seen !== mon_e.ss) begin
            bad++;
            $display("FAIL sb_start_seen cyc=%0d got=%b exp=%b", cyc, start_seen, mon_e.ss);
         end
         total++;
         if (locked !== mon_e.lk) begin
            bad++;
            $display("FAIL sb_locked cyc=%0d got=%b exp=%b", cyc, locked, mon_e.lk);
         end
         total++;
         if (err_cnt !== mon_e.ec) begin
            bad++;
            $display("FAIL sb_err_cnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt, mon_e.ec);
         end
         total++;
         if (frame_cnt !== mon_e.fc) begin
            bad++;
            $display("FAIL sb_frame_cnt cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, mon_e.fc);
         end
`ifdef OPTICAL_RX_BITERR_EN
         total++;
         if (bit_err_cnt !== mon_e.bc) begin
            bad++;
            $display("FAIL sb_bit_err_cnt cyc=%0d got=%0d exp=%0d", cyc, bit_err_cnt, mon_e.bc);
         end
`endif
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [47:0] next_payload();
      logic [47:0] p;
      bit          nb;
      p = 48'd0;
      for (int i = 47; i >= 0; i--) begin
         nb = hist[hist.size() - 31] ^ hist[hist.size() - 28];
         hist.push_back(nb);
         p[i] = nb;
      end
      return p;
   endfunction

   // Drive one word for one cycle and queue the outputs expected after it.
   task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v,
                        input logic c, input logic fe, input logic ss);
      exp_t e;
      rx_data    = d;
      rx_charisk = k;
      rx_valid   = v;
      clr_cnt    = c;
      e.due = cyc + 1;
      e.fe  = fe;
      e.ss  = ss;
      e.lk  = m_lk;
      e.ec  = m_err;
      e.fc  = m_frm;
      e.bc  = m_bit;
      sb.push_back(e);
      @(negedge clock);
   endtask

   task automatic clear_model();
      m_err = '0;
      m_frm = 32'd0;
      m_bit = 32'd0;
   endtask

   task automatic send_idle(input logic [31:0] d, input logic [3:0] k);
      drive(d, k, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_marker();
      m_st  = S_SEED;
      m_lk  = 1'b0;
      m_run = 0;
      drive(32'hFCFCFCFC, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_frame(input logic [47:0] flip, input logic [15:0] comma, input logic kbit,
                             input bit drop, input bit clr_hi, input bit clr_lo);
      logic [47:0] pl;
      logic        fe;
      logic [32:0] t;
      pl = next_payload() ^ flip;
      if (clr_hi) clear_model();
      drive(pl[47:16], 4'b0000, 1'b1, clr_hi, 1'b0, 1'b0);
      if (drop) begin
         m_st  = S_SEARCH;
         m_lk  = 1'b0;
         m_run = 0;
         drive(32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      fe = 1'b0;
      if (m_st == S_SEED) begin
         m_st  = S_CHECK;
         m_lk  = 1'b1;
         m_run = 0;
      end else if (m_st == S_CHECK) begin
         fe = (flip != 48'd0) || (comma != 16'hBC50) || (kbit != 1'b1);
         if (m_frm != 32'hFFFFFFFF) m_frm = m_frm + 32'd1;
         t = {1'b0, m_bit} + 33'($countones(flip));
         m_bit = t[32] ? 32'hFFFFFFFF : t[31:0];
         if (fe) begin
            if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
            m_run++;
            if (m_run >= LL) begin
               m_st  = S_SEARCH;
               m_lk  = 1'b0;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      if (clr_lo) clear_model();
      drive({pl[15:0], comma}, {2'b00, kbit, 1'b0}, 1'b1, clr_lo, fe, 1'b0);
   endtask

   task automatic good_frames(input int n);
      for (int i = 0; i < n; i++) send_frame(48'd0, 16'hBC50, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      hist.push_back(1'b1);
      for (int i = 0; i < 30; i++) hist.push_back(1'($urandom_range(0, 1)));
      m_st = S_SEARCH; m_run = 0; m_lk = 1'b0; clear_model();
      @(negedge clock);
      @(negedge clock);
      total++; if (locked !== 1'b0)     begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
      total++; if (start_seen !== 1'b0) begin bad++; $display("FAIL reset_start_seen got=%b exp=0", start_seen); end
      total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      total++; if (err_cnt !== 4'd0)    begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      total++; if (frame_cnt !== 32'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
      reset_n = 1'b1;
   endtask

   task automatic test_lock();
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) send_idle(32'h00000000, 4'b0000);
         else            send_idle(32'h1CFEFBDC, 4'b1111);
      end
      send_marker();
      good_frames(101);
      total++; if (frame_cnt !== 32'd100) begin bad++; $display("FAIL lock_frame_cnt got=%0d exp=100", frame_cnt); end
      total++; if (err_cnt !== 4'd0)      begin bad++; $display("FAIL lock_err_cnt got=%0d exp=0", err_cnt); end
      total++; if (locked !== 1'b1)       begin bad++; $display("FAIL lock_locked got=%b exp=1", locked); end
   endtask

   task automatic test_bit_flip();
      send_frame(48'h0000_0000_0020, 16'hBC50, 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL flip_frame_err got=%b exp=1", frame_err); end
      good_frames(3);
      total++; if (err_cnt !== 4'd1)      begin bad++; $display("FAIL flip_err_cnt got=%0d exp=1", err_cnt); end
      total++; if (locked !== 1'b1)       begin bad++; $display("FAIL flip_locked got=%b exp=1", locked); end
      total++; if (frame_cnt !== 32'd104) begin bad++; $display("FAIL flip_frame_cnt got=%0d exp=104", frame_cnt); end
`ifdef OPTICAL_RX_BITERR_EN
      total++; if (bit_err_cnt !== 32'd1) begin bad++; $display("FAIL flip_bit_err_cnt got=%0d exp=1", bit_err_cnt); end
`endif
   endtask

   task automatic test_comma_loss();
      for (int i = 0; i < 4; i++) send_frame(48'd0, 16'hBC51, 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (locked !== 1'b0)  begin bad++; $display("FAIL comma_locked got=%b exp=0", locked); end
      total++; if (err_cnt !== 4'd5) begin bad++; $display("FAIL comma_err_cnt got=%0d exp=5", err_cnt); end
      good_frames(2);
      total++; if (locked !== 1'b0)  begin bad++; $display("FAIL comma_still_unlocked got=%b exp=0", locked); end
      send_marker();
      good_frames(3);
      total++; if (locked !== 1'b1)  begin bad++; $display("FAIL comma_relock got=%b exp=1", locked); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) send_frame(48'd1 << $urandom_range(0, 47), 16'hBC50, 1'b1, 1'b0, 1'b0, 1'b0);
         else            send_frame(48'd0, 16'hBC50, 1'b0, 1'b0, 1'b0, 1'b0);
         good_frames(1);
      end
      total++; if (err_cnt !== 4'hF) begin bad++; $display("FAIL sat_err_cnt got=%0d exp=15", err_cnt); end
      total++; if (locked !== 1'b1)  begin bad++; $display("FAIL sat_locked got=%b exp=1", locked); end
      send_frame(48'd0, 16'hBC50, 1'b1, 1'b0, 1'b1, 1'b0);
      total++; if (frame_cnt !== 32'd1) begin bad++; $display("FAIL clr_frame_cnt got=%0d exp=1", frame_cnt); end
      send_frame(48'h8000_0000_0000, 16'hBC50, 1'b1, 1'b0, 1'b0, 1'b1);
      total++; if (err_cnt !== 4'd0)    begin bad++; $display("FAIL clr_wins_err_cnt got=%0d exp=0", err_cnt); end
      total++; if (frame_cnt !== 32'd0) begin bad++; $display("FAIL clr_wins_frame_cnt got=%0d exp=0", frame_cnt); end
   endtask

   task automatic test_valid_drop();
      good_frames(1);
      send_frame(48'd0, 16'hBC50, 1'b1, 1'b1, 1'b0, 1'b0);
      total++; if (locked !== 1'b0)    begin bad++; $display("FAIL drop_locked got=%b exp=0", locked); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL drop_frame_err got=%b exp=0", frame_err); end
      good_frames(2);
      send_marker();
      good_frames(2);
      total++; if (locked !== 1'b1)    begin bad++; $display("FAIL drop_relock got=%b exp=1", locked); end
   endtask

   task automatic test_reset_mid_traffic();
      rx_data    = 32'h12345678;
      rx_charisk = 4'b0000;
      rx_valid   = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (locked !== 1'b0)     begin bad++; $display("FAIL mid_reset_locked got=%b exp=0", locked); end
      total++; if (frame_cnt !== 32'd0) begin bad++; $display("FAIL mid_reset_frame_cnt got=%0d exp=0", frame_cnt); end
      total++; if (err_cnt !== 4'd0)    begin bad++; $display("FAIL mid_reset_err_cnt got=%0d exp=0", err_cnt); end
      sb.delete();
      m_st = S_SEARCH; m_run = 0; m_lk = 1'b0; clear_model();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      good_frames(2);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL post_reset_locked got=%b exp=0", locked); end
      send_marker();
      good_frames(2);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL post_reset_relock got=%b exp=1", locked); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_bit_flip();
      test_comma_loss();
      test_saturation();
      test_valid_drop();
      test_reset_mid_traffic();
      rx_valid = 1'b0;
      clr_cnt  = 1'b0;
      @(negedge clock);
      @(negedge clock);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
